data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder.sv | 116 +++++++++++
 tb/tb_data_mem_responder.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// MEM-stage data-memory bus between the pipeline (master) and the memory responder (slave).
// Request lines are held by the master until mem_ready; responses come back on the same bundle.
interface data_mem_responder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              mem_ready;
  logic              mem_stall;
  logic              err;

  modport master (
    output MemRead, MemWrite, addr, write_data,
    input  read_data, mem_ready, mem_stall, err
  );

  modport slave (
    input  MemRead, MemWrite, addr, write_data,
    output read_data, mem_ready, mem_stall, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder for the 8-bit pipelined core: captures one request in IDLE,
// waits WAIT_CYCLES states, performs the access on the edge into RESP and pulses mem_ready.
module data_mem_responder #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              op_wr_reg, op_wr_next;
  logic [ADDR_W-1:0] cap_addr_reg, cap_addr_next;
  logic [DATA_W-1:0] cap_data_reg, cap_data_next;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;
  logic              one_req;
  logic              both_req;
  logic              access_en;

  logic [DATA_W-1:0] mem_reg [DEPTH];

  assign one_req  = bus.MemRead ^ bus.MemWrite;
  assign both_req = bus.MemRead & bus.MemWrite;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    op_wr_next    = op_wr_reg;
    cap_addr_next = cap_addr_reg;
    cap_data_next = cap_data_reg;
    case (state_reg)
      S_IDLE: begin
        if (one_req) begin
          op_wr_next    = bus.MemWrite;
          cap_addr_next = bus.addr;
          cap_data_next = bus.write_data;
          if (WAIT_CYCLES == 0) begin
            state_next = S_RESP;
          end else begin
            cnt_next   = CNT_LOAD;
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = S_RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // The access uses the *_next capture values so a zero-wait request can go IDLE->RESP in one edge.
  assign access_en = (state_next == S_RESP) && (state_reg != S_RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= 4'd0;
      op_wr_reg    <= 1'b0;
      cap_addr_reg <= '0;
      cap_data_reg <= '0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      op_wr_reg    <= op_wr_next;
      cap_addr_reg <= cap_addr_next;
      cap_data_reg <= cap_data_next;
      err_reg      <= (state_reg == S_IDLE) && both_req;
      if (access_en && !op_wr_next) begin
        rdata_reg <= mem_reg[cap_addr_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (access_en && op_wr_next) begin
      mem_reg[cap_addr_next] <= cap_data_next;
    end
  end

  assign bus.read_data = rdata_reg;
  assign bus.err       = err_reg;
  assign bus.mem_ready = (state_reg == S_RESP);
  // Stall is dropped in RESP so the pipeline advances on the mem_ready cycle.
  assign bus.mem_stall = !reset &&
                         (((state_reg == S_IDLE) && one_req) || (state_reg == S_WAIT));

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: two builds (WAIT_CYCLES=2 and 0) checked every cycle
// against a timeline model, plus literal expectations from the test plan.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder_if #(.DATA_W(8), .ADDR_W(8)) b2 ();
  data_mem_responder_if #(.DATA_W(8), .ADDR_W(8)) b0 ();

  data_mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .bus(b2)
  );
  data_mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Timeline model: an accepted request at cycle c stalls c..c+W and completes at c+1+W.
  bit         on     [2];
  bit         pend_v [2];
  int         pend_rdy [2];
  bit         pend_wr [2];
  logic [7:0] pend_a [2];
  logic [7:0] pend_d [2];
  bit         err_q  [2];
  logic [7:0] exp_rd [2];
  logic [7:0] mmem   [2][256];

  task automatic model_step(int k, int w, logic rst, logic rd, logic wr, logic [7:0] a,
                            logic [7:0] d, logic act_ready, logic act_stall, logic act_err,
                            logic [7:0] act_rd);
    bit exp_ready, exp_stall, exp_err;
    string tag;
    tag = (k == 0) ? "w2" : "w0";
    if (rst) begin
      chk({tag, "_stall_in_reset"}, 32'(act_stall), 32'(0));
      if (on[k]) begin
        chk({tag, "_ready_in_reset"}, 32'(act_ready), 32'(0));
        chk({tag, "_err_in_reset"}, 32'(act_err), 32'(err_q[k]));
        chk({tag, "_rdata_in_reset"}, 32'(act_rd), 32'(exp_rd[k]));
      end
      on[k] = 1'b1;
      pend_v[k] = 1'b0;
      err_q[k] = 1'b0;
      exp_rd[k] = 8'h00;
      for (int i = 0; i < 256; i++) mmem[k][i] = 8'h00;
      return;
    end
    if (!on[k]) return;
    exp_ready = pend_v[k] && (cyc == pend_rdy[k]);
    if (exp_ready) begin
      if (pend_wr[k]) mmem[k][pend_a[k]] = pend_d[k];
      else            exp_rd[k] = mmem[k][pend_a[k]];
    end
    exp_err = err_q[k];
    err_q[k] = 1'b0;
    exp_stall = 1'b0;
    if (pend_v[k] && cyc < pend_rdy[k]) begin
      exp_stall = 1'b1;
    end else if (!pend_v[k]) begin
      if (rd ^ wr) begin
        exp_stall   = 1'b1;
        pend_v[k]   = 1'b1;
        pend_rdy[k] = cyc + 1 + w;
        pend_wr[k]  = wr;
        pend_a[k]   = a;
        pend_d[k]   = d;
      end else if (rd && wr) begin
        err_q[k] = 1'b1;
      end
    end
    if (exp_ready) pend_v[k] = 1'b0;
    chk({tag, "_ready"}, 32'(act_ready), 32'(exp_ready));
    chk({tag, "_stall"}, 32'(act_stall), 32'(exp_stall));
    chk({tag, "_err"},   32'(act_err),   32'(exp_err));
    chk({tag, "_rdata"}, 32'(act_rd),    32'(exp_rd[k]));
  endtask

  always @(negedge clk) begin
    model_step(0, 2, reset, b2.MemRead, b2.MemWrite, b2.addr, b2.write_data,
               b2.mem_ready, b2.mem_stall, b2.err, b2.read_data);
    model_step(1, 0, reset, b0.MemRead, b0.MemWrite, b0.addr, b0.write_data,
               b0.mem_ready, b0.mem_stall, b0.err, b0.read_data);
  end

  task automatic set_in(int k, logic rd, logic wr, logic [7:0] a, logic [7:0] d);
    if (k == 0) begin
      b2.MemRead = rd; b2.MemWrite = wr; b2.addr = a; b2.write_data = d;
    end else begin
      b0.MemRead = rd; b0.MemWrite = wr; b0.addr = a; b0.write_data = d;
    end
  endtask

  function automatic logic get_ready(int k);
    return (k == 0) ? b2.mem_ready : b0.mem_ready;
  endfunction

  function automatic logic [7:0] get_rd(int k);
    return (k == 0) ? b2.read_data : b0.read_data;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the request until mem_ready; lat counts edges from issue to the ready cycle.
  task automatic do_req(int k, logic rd, logic wr, logic [7:0] a, logic [7:0] d,
                        bit alt_en, logic [7:0] alt_a, output int lat);
    set_in(k, rd, wr, a, d);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 1 && alt_en) set_in(k, rd, wr, alt_a, d);
      if (get_ready(k)) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) chk("req_timeout", 32'(0), 32'(1));
  endtask

  int lat;
  int rdy_cyc, prev_rdy_cyc;
  int ready_seen;

  initial begin
    set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_in(1, 1'b0, 1'b0, 8'h00, 8'h00);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    chk("reset_rdata", 32'(b2.read_data), 32'(8'h00));
    chk("reset_ready", 32'(b2.mem_ready), 32'(0));
    chk("reset_stall", 32'(b2.mem_stall), 32'(0));
    chk("reset_err",   32'(b2.err),       32'(0));

    // Read 0x10: stall N..N+2, ready at N+3.
    set_in(0, 1'b1, 1'b0, 8'h10, 8'h00);
    for (int i = 0; i <= 3; i++) begin
      #1;
      chk($sformatf("t1_stall_n%0d", i), 32'(b2.mem_stall), 32'(i < 3));
      chk($sformatf("t1_ready_n%0d", i), 32'(b2.mem_ready), 32'(i == 3));
      if (i == 3) begin
        chk("t1_rdata", 32'(b2.read_data), 32'(8'h00));
        set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
      end
      step();
    end

    // Write then read back 0x3C.
    do_req(0, 1'b0, 1'b1, 8'h3C, 8'hA5, 1'b0, 8'h00, lat);
    chk("t2_wr_latency", 32'(lat), 32'(3));
    set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    do_req(0, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b0, 8'h00, lat);
    chk("t2_rd_latency", 32'(lat), 32'(3));
    chk("t2_rdata", 32'(get_rd(0)), 32'(8'hA5));
    set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();

    // Illegal both-high request for two cycles.
    set_in(0, 1'b1, 1'b1, 8'h05, 8'h77);
    step();
    chk("t3_err_1", 32'(b2.err), 32'(1));
    chk("t3_stall", 32'(b2.mem_stall), 32'(0));
    step();
    set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("t3_err_2", 32'(b2.err), 32'(1));
    step();
    chk("t3_err_off", 32'(b2.err), 32'(0));
    do_req(0, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 8'h00, lat);
    chk("t3_rdata", 32'(get_rd(0)), 32'(8'h00));
    set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();

    // Reset during WAIT of a write to 0xFF.
    set_in(0, 1'b0, 1'b1, 8'hFF, 8'h5A);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
    ready_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (b2.mem_ready) ready_seen++;
      step();
    end
    chk("t4_no_ready", 32'(ready_seen), 32'(0));
    do_req(0, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, lat);
    chk("t4_rdata", 32'(get_rd(0)), 32'(8'h00));
    set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();

    // Address changed during WAIT is ignored.
    do_req(0, 1'b0, 1'b1, 8'h08, 8'h11, 1'b0, 8'h00, lat);
    set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    do_req(0, 1'b0, 1'b1, 8'h20, 8'h22, 1'b0, 8'h00, lat);
    set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    do_req(0, 1'b1, 1'b0, 8'h08, 8'h00, 1'b1, 8'h20, lat);
    chk("t5_latency", 32'(lat), 32'(3));
    chk("t5_rdata", 32'(get_rd(0)), 32'(8'h11));
    set_in(0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();

    // Zero-wait build: preload 1..4, then back-to-back reads.
    for (int j = 0; j < 4; j++) begin
      do_req(1, 1'b0, 1'b1, 8'(j), 8'(j + 1), 1'b0, 8'h00, lat);
      chk($sformatf("t6_wr_latency_%0d", j), 32'(lat), 32'(1));
      set_in(1, 1'b0, 1'b0, 8'h00, 8'h00);
      step();
    end
    prev_rdy_cyc = 0;
    for (int j = 0; j < 4; j++) begin
      do_req(1, 1'b1, 1'b0, 8'(j), 8'h00, 1'b0, 8'h00, lat);
      rdy_cyc = cyc;
      chk($sformatf("t6_rdata_%0d", j), 32'(get_rd(1)), 32'(j + 1));
      if (j > 0) chk($sformatf("t6_spacing_%0d", j), 32'(rdy_cyc - prev_rdy_cyc), 32'(2));
      prev_rdy_cyc = rdy_cyc;
    end
    set_in(1, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
